mem_stage: RTL
==============

# mem_stage

MEM stage of the five-stage pipeline and the responder side of the memory request built during decode and execute. It accepts the execute stage's access (enable, address, store data, `mem_op`) and issues it to a data SRAM port that uses a req/addr_ok/data_ok handshake. It produces byte write strobes and aligns and extends load data. It also drives the MEM-stage forwarding bundle (`ms_valid`/`ms_rf_we`/`ms_rf_waddr`/`ms_rf_wdata`) that decode consumes.

## Interface
Parameters:
- `RESET_PC`, 32'h1c000000, reset value of `ms_pc`

Ports:
- `clk`  in  1  the single clock
- `reset`  in  1  asynchronous reset, active-low (0 = reset asserted)
- `es_to_ms_valid`  in  1  EXE holds a valid instruction
- `ms_allow_in`  out  1  MEM can accept this cycle
- `es_pc`  in  32  instruction PC
- `es_sram_en`  in  1  instruction accesses memory
- `es_mem_op`  in  4  bit[3] 1=load, 0=store; loads b=1000, h=1001, w=1010, bu=1100, hu=1101; stores b=0100, h=0101, w=0110; 0000 = none
- `es_addr`  in  32  byte address
- `es_wdata`  in  32  store data, already lane-replicated (b ×4, h ×2)
- `es_alu_result`  in  32  result for non-load instructions
- `es_rf_we`  in  4  register write enable
- `es_rf_waddr`  in  5  destination register
- `data_sram_req`  out  1  request valid
- `data_sram_wr`  out  1  1 = write
- `data_sram_wstrb`  out  4  byte strobes, 0000 for reads
- `data_sram_addr`  out  32  word address {addr[31:2], 2'b00}
- `data_sram_wdata`  out  32  store data
- `data_sram_addr_ok`  in  1  request accepted
- `data_sram_data_ok`  in  1  read data valid / write done
- `data_sram_rdata`  in  32  read data
- `ws_allow_in`  in  1  WB can accept
- `ms_to_ws_valid`  out  1  `ms_valid & ms_ready_go`
- `ms_valid`  out  1  stage holds an instruction
- `ms_fwd_ok`  out  1  `ms_rf_wdata` is final; decode must stall on a register match while this is 0
- `ms_pc`  out  32
- `ms_rf_we`  out  4
- `ms_rf_waddr`  out  5
- `ms_rf_wdata`  out  32

## Operation
- Stage register captures all `es_*` inputs when `es_to_ms_valid & ms_allow_in`.
- `ms_valid` becomes `es_to_ms_valid` whenever `ms_allow_in` is high.
- `ms_allow_in = !ms_valid | (ms_ready_go & ws_allow_in)`.
- Access is performed when `es_sram_en` is set and `mem_op` is a legal encoding; otherwise the instruction is non-memory.
- State machine:
  - IDLE: non-memory instruction, or no instruction held.
  - REQ: `data_sram_req` = 1, held until `addr_ok`.
  - WAIT: waiting for `data_ok`.
  - DONE: response captured.
- Transitions:
  - Capture of an access → REQ; capture of a non-access → IDLE.
  - REQ & `addr_ok` → WAIT.
  - WAIT & `data_ok` → DONE; `rdata` is latched on that edge.
  - Leaving the stage (`ms_to_ws_valid & ws_allow_in`) with no new capture → IDLE.
  - Leaving with a simultaneous capture → REQ or IDLE according to the new instruction.
- `ms_ready_go`: 1 in IDLE with `ms_valid`, 1 in DONE, 0 in REQ and WAIT.
- Write strobes, from `addr[1:0]`:
  - st.b: 4'b0001 << addr[1:0].
  - st.h: addr[1] ? 1100 : 0011; addr[0] is ignored.
  - st.w: 1111.
- Load data, from latched `rdata`:
  - b/bu select byte `addr[1:0]`.
  - h/hu select half `addr[1]`.
  - b/h sign-extend; bu/hu zero-extend; w passes through.
- `ms_rf_wdata` = aligned load data for loads, `alu_result` otherwise. For stores, `ms_rf_we` is passed through as received, which is 0 from decode.
- `ms_fwd_ok` = !(load & state != DONE).
- SRAM request outputs are driven from stage registers only, with no combinational path from `es_*`.

## Timing
- Reset values:
  - `ms_valid` = 0, state = IDLE, `data_sram_req` = 0, `data_sram_wr` = 0.
  - `data_sram_wstrb` = 0, `data_sram_addr` = 0, `data_sram_wdata` = 0.
  - `ms_pc` = `RESET_PC`, `ms_rf_we` = 0, `ms_rf_waddr` = 0, `ms_rf_wdata` = 0, `ms_fwd_ok` = 1.
- Non-memory instruction: 1 cycle in stage when WB accepts.
- Access: capture edge, then REQ cycle(s), then WAIT until `data_ok`, then DONE. Minimum 3 cycles for zero-wait SRAM (`addr_ok` in the first REQ cycle, `data_ok` the next cycle).
- `data_ok` for a request never coincides with that request's `addr_ok`. At most one request is outstanding.
- `data_ok` in IDLE, REQ or DONE is ignored.
- DONE holds the latched data across WB backpressure.
- Reset mid-access drops the access; the SRAM shares the same reset.

## Structure
- Shared package: `mem_op` encodings, `MEM_LOAD_BIT`, state encoding (IDLE/REQ/WAIT/DONE).
- Sub-module `mem_load_align`: combinational (`rdata`, `addr[1:0]`, `mem_op`) → 32-bit extended result.

## Test plan
- ld.b, addr 0x1c001003, rdata 0x80112233, zero-wait SRAM → `data_sram_addr` 0x1c001000, wstrb 0000, `ms_rf_wdata` 0xffffff80, `ms_to_ws_valid` 3 cycles after capture.
- ld.hu, addr offset 2, rdata 0x8001abcd → 0x00008001. ld.h, addr offset 0, rdata 0x1234f00d → 0xfffff00d.
- st.b, addr offset 2, wdata 0x5a5a5a5a → `data_sram_wr` 1, wstrb 0100. st.h, addr offset 3 → wstrb 1100.
- `addr_ok` delayed 3 cycles, `data_ok` delayed 2 → req stays high 4 cycles, `ms_allow_in` 0 throughout, `ms_fwd_ok` 0 until DONE.
- add (non-memory) followed by load, `ws_allow_in` 0 for 2 cycles → add held with `ms_rf_wdata` = alu_result. Load captured on the edge the add leaves; no SRAM req while the add is held.
- reset asserted in WAIT → `ms_valid` 0 and req 0 asynchronously; a later stray `data_ok` does not change state.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the MEM stage: mem_op encodings, the load/store
//   flag bit position, the access state encoding, and helpers that classify
//   mem_op and build store byte strobes.
//   Encoding 4'b0000 means "no memory access" and is treated as illegal for access.
package mem_stage_pkg;

    localparam int MEM_LOAD_BIT = 3;  // mem_op[3]: 1 = load, 0 = store

    localparam logic [3:0] OP_LD_B  = 4'b1000;
    localparam logic [3:0] OP_LD_H  = 4'b1001;
    localparam logic [3:0] OP_LD_W  = 4'b1010;
    localparam logic [3:0] OP_LD_BU = 4'b1100;
    localparam logic [3:0] OP_LD_HU = 4'b1101;
    localparam logic [3:0] OP_ST_B  = 4'b0100;
    localparam logic [3:0] OP_ST_H  = 4'b0101;
    localparam logic [3:0] OP_ST_W  = 4'b0110;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,  // no instruction, or a non-memory instruction
        MS_REQ  = 2'd1,  // request presented, waiting for addr_ok
        MS_WAIT = 2'd2,  // request accepted, waiting for data_ok
        MS_DONE = 2'd3   // response captured, ready to hand to WB
    } ms_state_e;

    // True only for the eight encodings that perform an access.
    function automatic logic mem_op_legal(input logic [3:0] op);
        case (op)
            OP_LD_B, OP_LD_H, OP_LD_W, OP_LD_BU, OP_LD_HU,
            OP_ST_B, OP_ST_H, OP_ST_W: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Byte strobes for a store; zero for any non-store encoding.
    // Halfword stores ignore addr[0].
    function automatic logic [3:0] store_wstrb(input logic [3:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_ST_B: return 4'b0001 << addr_lo;
            OP_ST_H: return addr_lo[1] ? 4'b1100 : 4'b0011;
            OP_ST_W: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if
//   Data SRAM port with a req/addr_ok/data_ok handshake.
//   master (MEM stage): drives data_sram_req/wr/wstrb/addr/wdata,
//                       receives data_sram_addr_ok/data_ok/rdata.
//   slave  (SRAM):      the reverse.
interface mem_stage_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align
//   Combinational load data alignment and extension.
//   rdata   in  32  word returned by the data SRAM
//   addr_lo in   2  byte offset of the load address
//   mem_op  in   4  load encoding (b/h/w/bu/hu)
//   result  out 32  selected byte/half, sign- or zero-extended; word as-is
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  mem_op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case statements can infer a latch.
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        case (mem_op)
            OP_LD_B:  result = {{24{byte_sel[7]}}, byte_sel};
            OP_LD_BU: result = {24'd0, byte_sel};
            OP_LD_H:  result = {{16{half_sel[15]}}, half_sel};
            OP_LD_HU: result = {16'd0, half_sel};
            default:  result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   MEM pipeline stage. Holds one instruction from EXE, issues its memory
//   access on the data SRAM port, aligns load data, and presents the
//   result plus a forwarding bundle to decode and WB.
//   clk, reset (async, active-low)
//   EXE side : es_to_ms_valid, ms_allow_in, es_pc, es_sram_en, es_mem_op,
//              es_addr, es_wdata, es_alu_result, es_rf_we, es_rf_waddr
//   SRAM side: sram (mem_stage_if.master)
//   WB side  : ws_allow_in, ms_to_ws_valid
//   Forward  : ms_valid, ms_fwd_ok, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        es_to_ms_valid,
    output logic        ms_allow_in,
    input  logic [31:0] es_pc,
    input  logic        es_sram_en,
    input  logic [3:0]  es_mem_op,
    input  logic [31:0] es_addr,
    input  logic [31:0] es_wdata,
    input  logic [31:0] es_alu_result,
    input  logic [3:0]  es_rf_we,
    input  logic [4:0]  es_rf_waddr,

    mem_stage_if.master sram,

    input  logic        ws_allow_in,
    output logic        ms_to_ws_valid,
    output logic        ms_valid,
    output logic        ms_fwd_ok,
    output logic [31:0] ms_pc,
    output logic [3:0]  ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic [31:0] ms_rf_wdata
);

    ms_state_e   state_q, state_d;
    logic        access_q;
    logic [3:0]  mem_op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] alu_result_q;
    logic [31:0] rdata_q;
    logic [31:0] load_result;

    logic ms_ready_go;
    logic capture;
    logic leave;
    logic es_access;
    logic is_load;

    assign es_access      = es_sram_en & mem_op_legal(es_mem_op);
    assign ms_ready_go    = (state_q == MS_IDLE && ms_valid) || (state_q == MS_DONE);
    assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    assign capture        = es_to_ms_valid & ms_allow_in;
    assign leave          = ms_to_ws_valid & ws_allow_in;
    assign is_load        = access_q & mem_op_q[MEM_LOAD_BIT];

    // A new capture overrides the departure of the old instruction; only
    // the handshake inputs matter once the access is in flight.
    always_comb begin
        state_d = state_q;
        if (capture) begin
            state_d = es_access ? MS_REQ : MS_IDLE;
        end else if (leave) begin
            state_d = MS_IDLE;
        end else begin
            case (state_q)
                MS_REQ:  if (sram.data_sram_addr_ok) state_d = MS_WAIT;
                MS_WAIT: if (sram.data_sram_data_ok) state_d = MS_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= MS_IDLE;
            ms_valid     <= 1'b0;
            access_q     <= 1'b0;
            mem_op_q     <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            alu_result_q <= 32'd0;
            rdata_q      <= 32'd0;
            ms_pc        <= RESET_PC;
            ms_rf_we     <= 4'd0;
            ms_rf_waddr  <= 5'd0;
        end else begin
            state_q <= state_d;
            if (ms_allow_in) begin
                ms_valid <= es_to_ms_valid;
            end
            if (capture) begin
                access_q     <= es_access;
                mem_op_q     <= es_mem_op;
                addr_q       <= es_addr;
                wdata_q      <= es_wdata;
                alu_result_q <= es_alu_result;
                ms_pc        <= es_pc;
                ms_rf_we     <= es_rf_we;
                ms_rf_waddr  <= es_rf_waddr;
            end
            // data_ok outside WAIT belongs to nothing we own and is dropped.
            if (state_q == MS_WAIT && sram.data_sram_data_ok) begin
                rdata_q <= sram.data_sram_rdata;
            end
        end
    end

    // SRAM request fields come only from stage registers, so the request
    // stays stable while addr_ok is pending and has no path from EXE.
    assign sram.data_sram_req   = (state_q == MS_REQ);
    assign sram.data_sram_wr    = access_q & ~mem_op_q[MEM_LOAD_BIT];
    assign sram.data_sram_wstrb = access_q ? store_wstrb(mem_op_q, addr_q[1:0]) : 4'b0000;
    assign sram.data_sram_addr  = {addr_q[31:2], 2'b00};
    assign sram.data_sram_wdata = wdata_q;

    mem_load_align u_load_align (
        .rdata   (rdata_q),
        .addr_lo (addr_q[1:0]),
        .mem_op  (mem_op_q),
        .result  (load_result)
    );

    assign ms_rf_wdata = is_load ? load_result : alu_result_q;
    // A load's register value is unknown until the response is captured.
    assign ms_fwd_ok   = !(is_load && state_q != MS_DONE);

endmodule
